// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Brief   : Operation encoding and helpers shared by the 64-bit ALU.
// Revision: 1.0
// ============================================================================
package alu_pkg;

  localparam int unsigned ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_PASS_B   = 3'b000,
    ALU_ADD      = 3'b010,
    ALU_SUBTRACT = 3'b011,
    ALU_AND      = 3'b100,
    ALU_OR       = 3'b101,
    ALU_XOR      = 3'b110
  } alu_op_t;

  function automatic logic is_arith(input alu_op_t op);
    return (op == ALU_ADD) || (op == ALU_SUBTRACT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu64_if.sv
`default_nettype none
// ============================================================================
// Module  : alu64_if
// Brief   : Operand/opcode bundle into the ALU and registered result/flags out.
// Revision: 1.0
// ============================================================================
interface alu64_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       cntrl;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry_out;

  modport master (
    output A, B, cntrl,
    input  result, negative, zero, overflow, carry_out
  );

  modport slave (
    input  A, B, cntrl,
    output result, negative, zero, overflow, carry_out
  );
endinterface
`default_nettype wire

// File: rtl/alu_bitslice.sv
`default_nettype none
// ============================================================================
// Module  : alu_bitslice
// Brief   : One bit of the ALU: full adder with optional B inversion + logic mux.
// Revision: 1.0
// ============================================================================
module alu_bitslice
  import alu_pkg::*;
(
  input  wire logic    a,
  input  wire logic    b,
  input  wire logic    cin,
  input  wire logic    invert_b,
  input  wire alu_op_t op,
  output logic         r,
  output logic         cout
);

  logic w_b_eff;
  logic w_sum;

  assign w_b_eff = b ^ invert_b;
  assign w_sum   = a ^ w_b_eff ^ cin;
  assign cout    = (a & w_b_eff) | (cin & (a ^ w_b_eff));

  // Logic ops use the raw B operand; inversion only applies to subtraction.
  always_comb begin
    r = 1'b0;
    case (op)
      ALU_PASS_B:            r = b;
      ALU_ADD, ALU_SUBTRACT: r = w_sum;
      ALU_AND:               r = a & b;
      ALU_OR:                r = a | b;
      ALU_XOR:               r = a ^ b;
      default:               r = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu64.sv
`default_nettype none
// ============================================================================
// Module  : alu64
// Brief   : Ripple-carry 64-bit ALU with registered result and NZVC flags.
// Revision: 1.0
// ============================================================================
module alu64
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  wire logic clk,
  input  wire logic reset,
  alu64_if.slave    bus
);

  alu_op_t          w_op;
  logic             w_is_sub;
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_slice_r;

  logic [WIDTH-1:0] result_d,    result_q;
  logic             negative_d,  negative_q;
  logic             zero_d,      zero_q;
  logic             overflow_d,  overflow_q;
  logic             carry_out_d, carry_out_q;

  // Reserved encodings fall through to the slices' default and yield zero.
  assign w_op       = alu_op_t'(bus.cntrl);
  assign w_is_sub   = (w_op == ALU_SUBTRACT);
  assign w_carry[0] = w_is_sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    alu_bitslice u_slice (
      .a        (bus.A[i]),
      .b        (bus.B[i]),
      .cin      (w_carry[i]),
      .invert_b (w_is_sub),
      .op       (w_op),
      .r        (w_slice_r[i]),
      .cout     (w_carry[i+1])
    );
  end

  always_comb begin
    result_d    = w_slice_r;
    negative_d  = w_slice_r[WIDTH-1];
    zero_d      = ~|w_slice_r;
    overflow_d  = 1'b0;
    carry_out_d = 1'b0;
    if (is_arith(w_op)) begin
      overflow_d  = w_carry[WIDTH] ^ w_carry[WIDTH-1];
      carry_out_d = w_carry[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q    <= '0;
      negative_q  <= 1'b0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      carry_out_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      negative_q  <= negative_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      carry_out_q <= carry_out_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.negative  = negative_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;
  assign bus.carry_out = carry_out_q;

endmodule
`default_nettype wire

// File: tb/tb_alu64.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu64
// Brief   : Directed scoreboard bench for alu64 with one-cycle latency checks.
// Revision: 1.0
// ============================================================================
module tb_alu64;

  typedef struct packed {
    logic [63:0] r;
    logic        n;
    logic        z;
    logic        v;
    logic        c;
  } exp_t;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  exp_t sb[$];

  alu64_if #(.WIDTH(64)) bus ();

  alu64 #(.WIDTH(64)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [63:0] r, input logic n, input logic z,
                              input logic v, input logic c);
    exp_t e;
    e.r = r; e.n = n; e.z = z; e.v = v; e.c = c;
    return e;
  endfunction

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input exp_t e);
    vectors++;
    assert (bus.result === e.r) else begin
      miscompares++;
      $error("FAIL %s.result observed=%h expected=%h", tag, bus.result, e.r);
    end
    chk_bit({tag, ".N"}, bus.negative,  e.n);
    chk_bit({tag, ".Z"}, bus.zero,      e.z);
    chk_bit({tag, ".V"}, bus.overflow,  e.v);
    chk_bit({tag, ".C"}, bus.carry_out, e.c);
  endtask

  // Drive on the falling edge, then expect the value exactly one rising edge later.
  task automatic step(input string tag, input logic [63:0] a, input logic [63:0] b,
                      input logic [2:0] op, input logic rst_in, input exp_t e);
    exp_t got;
    @(negedge clk);
    reset     = rst_in;
    bus.A     = a;
    bus.B     = b;
    bus.cntrl = op;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      got = sb.pop_front();
      chk_outputs(tag, got);
    end
  endtask

  initial begin
    logic [63:0] rb;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.A       = 64'h0;
    bus.B       = 64'h0;
    bus.cntrl   = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs("reset_state", mk(64'h0, 1'b0, 1'b0, 1'b0, 1'b0));

    // PASS_B with random operands
    for (int i = 0; i < 5; i++) begin
      rb = {$urandom, $urandom};
      step("pass_b_rand", {$urandom, $urandom}, rb, 3'b000, 1'b0,
           mk(rb, rb[63], rb == 64'h0, 1'b0, 1'b0));
    end
    step("pass_b_zero", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3'b000, 1'b0,
         mk(64'h0, 1'b0, 1'b1, 1'b0, 1'b0));

    // ADD
    step("add_1_1", 64'h1, 64'h1, 3'b010, 1'b0,
         mk(64'h2, 1'b0, 1'b0, 1'b0, 1'b0));
    step("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 3'b010, 1'b0,
         mk(64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b0));
    step("add_carry", 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 3'b010, 1'b0,
         mk(64'hF, 1'b0, 1'b0, 1'b0, 1'b1));
    step("add_neg_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b010, 1'b0,
         mk(64'h0, 1'b0, 1'b1, 1'b1, 1'b1));

    // SUB
    step("sub_1_1", 64'h1, 64'h1, 3'b011, 1'b0,
         mk(64'h0, 1'b0, 1'b1, 1'b0, 1'b1));
    step("sub_11_1", 64'h11, 64'h1, 3'b011, 1'b0,
         mk(64'h10, 1'b0, 1'b0, 1'b0, 1'b1));
    step("sub_1_11", 64'h1, 64'h11, 3'b011, 1'b0,
         mk(64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 1'b0, 1'b0, 1'b0));
    step("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 3'b011, 1'b0,
         mk(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1));

    // Logic ops; all-ones AND would carry in the adder but must not flag it
    step("and_1_0", 64'h1, 64'h0, 3'b100, 1'b0,
         mk(64'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    step("and_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 1'b0,
         mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0));
    step("or_aa_55", 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 3'b101, 1'b0,
         mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0));
    step("xor_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b110, 1'b0,
         mk(64'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    step("xor_ee_22", 64'hEEEE_EEEE_EEEE_EEEE, 64'h2222_2222_2222_2222, 3'b110, 1'b0,
         mk(64'hCCCC_CCCC_CCCC_CCCC, 1'b1, 1'b0, 1'b0, 1'b0));

    // Reserved encodings
    step("rsvd_001", 64'hFFFF_FFFF_FFFF_FFFF, 64'h3, 3'b001, 1'b0,
         mk(64'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    step("rsvd_111", 64'h5, 64'hFFFF_FFFF_FFFF_FFFF, 3'b111, 1'b0,
         mk(64'h0, 1'b0, 1'b1, 1'b0, 1'b0));

    // Reset with an overflowing op in flight discards it
    step("pre_reset", 64'h1, 64'h2, 3'b010, 1'b0,
         mk(64'h3, 1'b0, 1'b0, 1'b0, 1'b0));
    step("reset_inflight", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 3'b010, 1'b1,
         mk(64'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    step("post_reset", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'b010, 1'b0,
         mk(64'h0, 1'b0, 1'b1, 1'b0, 1'b1));

    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
